// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NUM_CH requesters onto one memory port.
// Optional watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH*ADDR_W-1:0]       ch_address,
    input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_byte_enable,
    output logic [NUM_CH-1:0]              ch_resp,
    output logic [DATA_W-1:0]              ch_rdata,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_address,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic [DATA_W/8-1:0]            mem_byte_enable,
    input  logic                           mem_resp,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic                           timeout_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int GW   = $clog2(NUM_CH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     grant_nx;
    logic [GW-1:0]     cand;
    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic              found;
    logic              is_wr;
    logic              tmo;
    logic              done;

    assign req     = ch_read | ch_write;
    assign any_req = |req;
    assign done    = mem_resp | tmo;

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        grant_nx = grant;
        found    = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = GW'((int'(grant) + i) % NUM_CH);
            if (!found && req[cand]) begin
                grant_nx = cand;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (any_req) state_nx = BUSY;
            BUSY: if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Granted request is captured once; the memory port runs from these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant           <= GW'(NUM_CH - 1);
            is_wr           <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else if (state == IDLE && any_req) begin
            grant           <= grant_nx;
            is_wr           <= ch_write[grant_nx];
            mem_address     <= ch_address[int'(grant_nx)*ADDR_W +: ADDR_W];
            mem_wdata       <= ch_wdata[int'(grant_nx)*DATA_W +: DATA_W];
            mem_byte_enable <= ch_byte_enable[int'(grant_nx)*BE_W +: BE_W];
        end
    end

    always_comb begin
        mem_read  = (state == BUSY) && !is_wr;
        mem_write = (state == BUSY) && is_wr;
        ch_resp   = '0;
        if (state == BUSY && done) begin
            ch_resp[grant] = 1'b1;
        end
        ch_rdata = tmo ? '0 : mem_rdata;
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt;
    logic          wd_err;

    assign tmo = (state == BUSY) && !mem_resp &&
                 (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = wd_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (!done) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
            if (tmo) begin
                wd_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases, then random traffic
// checked by a scoreboard against a round-robin reference model.
module tb_mem_arbiter;

    localparam int NC    = 4;
    localparam int N_TXN = 150;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] ch_read;
    logic [NC-1:0] ch_write;
    logic [NC*32-1:0] ch_address;
    logic [NC*32-1:0] ch_wdata;
    logic [NC*4-1:0]  ch_byte_enable;
    logic [NC-1:0] ch_resp;
    logic [31:0]   ch_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byte_enable;
    logic          mem_resp;
    logic [31:0]   mem_rdata;
    logic          timeout_err;

    mem_arbiter #(
        .NUM_CH(NC), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata),
        .ch_byte_enable(ch_byte_enable),
        .ch_resp(ch_resp), .ch_rdata(ch_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int phase    = 0;
    int issued   = 0;
    int done_cnt = 0;
    int mlast    = NC - 1;
    bit spur     = 1'b0;
    bit served  [NC];
    bit granted [NC];
    bit pending [NC];

    txn_t        exp_q [NC][$];
    txn_t        obs_q [$];
    int          grant_q [$];
    logic [31:0] rdata_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int c, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        ch_read[c]             = rd;
        ch_write[c]            = wr;
        ch_address[c*32 +: 32] = a;
        ch_wdata[c*32 +: 32]   = d;
        ch_byte_enable[c*4 +: 4] = be;
    endtask

    task automatic dir_txn(input int c, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int lat,
                           input logic [31:0] rdata);
        @(negedge clk);
        set_ch(c, rd, wr, a, d, be);
        @(posedge clk); #1;
        check("dir_mem_read", 32'(mem_read), 32'(rd && !wr));
        check("dir_mem_write", 32'(mem_write), 32'(wr));
        check("dir_addr", mem_address, a);
        check("dir_wdata", mem_wdata, d);
        check("dir_be", 32'(mem_byte_enable), 32'(be));
        for (int k = 0; k < lat; k++) begin
            @(posedge clk); #1;
            check("dir_hold_write", 32'(mem_write), 32'(wr));
            check("dir_hold_addr", mem_address, a);
            check("dir_no_early_resp", 32'(ch_resp), 0);
        end
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        #1;
        check("dir_resp", 32'(ch_resp), 32'(1) << c);
        check("dir_rdata", ch_rdata, rdata);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        set_ch(c, 1'b0, 1'b0, '0, '0, '0);
        check("dir_resp_clear", 32'(ch_resp), 0);
        check("dir_port_idle", 32'({mem_read, mem_write}), 0);
    endtask

    // Stimulus: channels raise requests at random and hold them until served.
    initial begin
        wait (phase == 1);
        while (phase == 1) begin
            @(posedge clk); #2;
            for (int c = 0; c < NC; c++) begin
                if (served[c]) begin
                    served[c]  = 1'b0;
                    granted[c] = 1'b0;
                    pending[c] = 1'b0;
                    ch_read[c] = 1'b0;
                    ch_write[c] = 1'b0;
                end else if (pending[c] && granted[c] &&
                             $urandom_range(0, 5) == 0) begin
                    ch_read[c]  = 1'b0;
                    ch_write[c] = 1'b0;
                end
                if (!pending[c] && issued < N_TXN &&
                    $urandom_range(0, 2) == 0) begin
                    int   k;
                    txn_t t;
                    k       = $urandom_range(0, 2);
                    t.wr    = (k != 0);
                    t.addr  = $urandom;
                    t.wdata = $urandom;
                    t.be    = 4'($urandom_range(0, 15));
                    set_ch(c, k != 1, k != 0, t.addr, t.wdata, t.be);
                    exp_q[c].push_back(t);
                    pending[c] = 1'b1;
                    issued++;
                end
            end
        end
    end

    // Memory model plus round-robin grant prediction.
    initial begin
        bit   in_txn;
        bit   skip;
        int   delay;
        int   g;
        txn_t cur;
        in_txn = 1'b0;
        delay  = 0;
        wait (phase == 1);
        while (phase == 1) begin
            @(posedge clk); #1;
            spur = 1'b0;
            skip = 1'b0;
            if (mem_resp) begin
                mem_resp = 1'b0;
                if (in_txn) begin
                    in_txn = 1'b0;
                    skip   = 1'b1;
                    check("port_drops_after_resp",
                          32'({mem_read, mem_write}), 0);
                end
            end
            if (!skip) begin
                if (in_txn) begin
                    check("stable_write", 32'(mem_write), 32'(cur.wr));
                    check("stable_read", 32'(mem_read), 32'(!cur.wr));
                    check("stable_addr", mem_address, cur.addr);
                    check("stable_wdata", mem_wdata, cur.wdata);
                    check("stable_be", 32'(mem_byte_enable), 32'(cur.be));
                end else if (mem_read || mem_write) begin
                    g = -1;
                    for (int k = 1; k <= NC; k++) begin
                        int c;
                        c = (mlast + k) % NC;
                        if (g < 0 && (ch_read[c] || ch_write[c])) g = c;
                    end
                    if (g < 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL grant_without_request: got %b expected 0",
                                 {mem_read, mem_write});
                    end else begin
                        grant_q.push_back(g);
                        mlast      = g;
                        granted[g] = 1'b1;
                    end
                    check("read_xor_write", 32'(mem_read ^ mem_write), 1);
                    cur.wr    = mem_write;
                    cur.addr  = mem_address;
                    cur.wdata = mem_wdata;
                    cur.be    = mem_byte_enable;
                    obs_q.push_back(cur);
                    in_txn = 1'b1;
                    delay  = $urandom_range(0, 3);
                end
                if (in_txn) begin
                    if (delay == 0) begin
                        mem_rdata = $urandom;
                        rdata_q.push_back(mem_rdata);
                        mem_resp = 1'b1;
                    end else begin
                        delay--;
                    end
                end else if ($urandom_range(0, 5) == 0) begin
                    mem_rdata = $urandom;
                    mem_resp  = 1'b1;
                    spur      = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (phase == 1) begin
            if (spur) check("idle_resp_ignored", 32'(ch_resp), 0);
            if (ch_resp != '0) begin
                if (grant_q.size() == 0 || obs_q.size() == 0 ||
                    rdata_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_resp: got %b expected 0", ch_resp);
                end else begin
                    int          g;
                    txn_t        o;
                    txn_t        e;
                    logic [31:0] rd;
                    g  = grant_q.pop_front();
                    o  = obs_q.pop_front();
                    rd = rdata_q.pop_front();
                    check("resp_channel", 32'(ch_resp), 32'(1) << g);
                    check("resp_rdata", ch_rdata, rd);
                    if (exp_q[g].size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL grant_order: got ch%0d expected idle channel", g);
                    end else begin
                        e = exp_q[g].pop_front();
                        check("txn_kind", 32'(o.wr), 32'(e.wr));
                        check("txn_addr", o.addr, e.addr);
                        check("txn_be", 32'(o.be), 32'(e.be));
                        if (e.wr) check("txn_wdata", o.wdata, e.wdata);
                    end
                    served[g] = 1'b1;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        ch_read        = '0;
        ch_write       = '0;
        ch_address     = '0;
        ch_wdata       = '0;
        ch_byte_enable = '0;
        mem_resp       = 1'b0;
        mem_rdata      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_addr", mem_address, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", 32'(mem_byte_enable), 0);
        check("rst_ch_resp", 32'(ch_resp), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        @(negedge clk);
        rst = 1'b0;

        dir_txn(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 2, 32'hDEADBEEF);
        dir_txn(2, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011, 3, 32'h0);
        dir_txn(2, 1'b1, 1'b0, 32'h204, 32'h0, 4'hF, 0, 32'hCAFEF00D);
        dir_txn(1, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 4'b1100, 1, 32'h0);

`ifdef MEM_ARBITER_TIMEOUT_EN
        @(negedge clk);
        set_ch(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("wd_busy", 32'(mem_read), 1);
        check("wd_no_resp_c1", 32'(ch_resp), 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("wd_no_resp", 32'(ch_resp), 0);
        end
        @(posedge clk); #1;
        check("wd_resp", 32'(ch_resp), 1);
        check("wd_rdata_zero", ch_rdata, 0);
        set_ch(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        check("wd_resp_clear", 32'(ch_resp), 0);
        check("wd_idle", 32'(mem_read), 0);
        check("wd_err_set", 32'(timeout_err), 1);
        repeat (3) @(posedge clk);
        #1;
        check("wd_err_sticky", 32'(timeout_err), 1);
`endif

        @(negedge clk);
        set_ch(3, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        @(posedge clk); #1;
        check("rstbusy_read", 32'(mem_read), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstbusy_drop", 32'(mem_read), 0);
        check("rstbusy_resp", 32'(ch_resp), 0);
        check("rstbusy_addr", mem_address, 0);
        check("rstbusy_err", 32'(timeout_err), 0);
        set_ch(3, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst       = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = 32'h1234;
        #1;
        check("late_resp_ignored", 32'(ch_resp), 0);
        @(posedge clk); #1;
        check("late_resp_idle", 32'({mem_read, mem_write}), 0);
        mem_resp = 1'b0;

        mlast = NC - 1;
        phase = 1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (issued == N_TXN && done_cnt == issued) break;
        end
        repeat (3) @(posedge clk);
        phase = 2;
        check("all_served", done_cnt, N_TXN);
        check("no_lost_grants", grant_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
